// File: rtl/matrix_pkg.sv
// Shared constants, FSM state type and element-index helper for the 64x64 matrix loader/selector.
package matrix_pkg;

   localparam int ELEM_W        = 16;
   localparam int DIM           = 64;
   localparam int BEAT_ELEMS    = 16;
   localparam int TILE_DIM      = 16;
   localparam int BEATS_PER_ROW = DIM / BEAT_ELEMS;
   localparam int BEATS_PER_MAT = 256;
   localparam int BEAT_W        = ELEM_W * BEAT_ELEMS;
   localparam int MAT_W         = ELEM_W * DIM * DIM;

   typedef enum logic {
      FILL = 1'b0,
      HOLD = 1'b1
   } state_t;

   // Bit offset of element (r,c) in the flattened row-major matrix.
   function automatic int idx(input int r, input int c);
      return ELEM_W * (DIM * r + c);
   endfunction

endpackage

// File: rtl/matrix_load_64.sv
// Streams 256-bit weight beats row-major into a 64x64 signed 16-bit matrix register and holds it until acked.
// Optional MATRIX_LOAD_ZERO_PAD_EN: in_last ends a partial block early and ack clears the matrix.
module matrix_load_64
   import matrix_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst,
   input  logic [BEAT_W-1:0]    in_data,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_last,
   output logic [MAT_W-1:0]     mat_data,
   output logic                 mat_valid,
   input  logic                 mat_ack,
   output logic [6:0]           rows_loaded
);

   state_t      state, state_nxt;
   logic [7:0]  beat_cnt, beat_cnt_nxt;
   logic        accept;
   logic        block_end;
   logic        clr;

`ifdef MATRIX_LOAD_ZERO_PAD_EN
   assign block_end = (beat_cnt == 8'(BEATS_PER_MAT - 1)) || in_last;
   assign clr       = (state == HOLD) && mat_ack;
`else
   logic unused_last;
   assign unused_last = in_last;
   assign block_end   = (beat_cnt == 8'(BEATS_PER_MAT - 1));
   assign clr         = 1'b0;
`endif

   assign accept = in_valid && (state == FILL);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= FILL;
         beat_cnt <= '0;
      end else begin
         state    <= state_nxt;
         beat_cnt <= beat_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      beat_cnt_nxt = beat_cnt;
      case (state)
         FILL: begin
            if (accept) begin
               beat_cnt_nxt = beat_cnt + 8'd1;
               if (block_end) begin
                  state_nxt    = HOLD;
                  beat_cnt_nxt = '0;
               end
            end
         end
         HOLD: begin
            if (mat_ack) state_nxt = FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // Handshake outputs come straight from the state register.
   assign in_ready    = (state == FILL);
   assign mat_valid   = (state == HOLD);
   assign rows_loaded = (state == HOLD) ? 7'd64 : {1'b0, beat_cnt[7:2]};

   // Beat b covers row b/4, columns 16*(b%4)..+15, which is one contiguous 256-bit slot.
   for (genvar b = 0; b < BEATS_PER_MAT; b++) begin : g_slot
      logic [BEAT_W-1:0] slot_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst)
            slot_q <= '0;
         else if (clr)
            slot_q <= '0;
         else if (accept && (beat_cnt == 8'(b)))
            slot_q <= in_data;
      end

      assign mat_data[idx(b / BEATS_PER_ROW, BEAT_ELEMS * (b % BEATS_PER_ROW)) +: BEAT_W] = slot_q;
   end

endmodule

// File: tb/tb_matrix_load_64.sv
// Randomized scoreboard bench for matrix_load_64 against an element-array reference model.
module tb_matrix_load_64;
   import matrix_pkg::*;

   logic               clk = 1'b0;
   logic               rst;
   logic [BEAT_W-1:0]  in_data;
   logic               in_valid;
   logic               in_ready;
   logic               in_last;
   logic [MAT_W-1:0]   mat_data;
   logic               mat_valid;
   logic               mat_ack;
   logic [6:0]         rows_loaded;

   matrix_load_64 dut (
      .clk         (clk),
      .rst         (rst),
      .in_data     (in_data),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_last     (in_last),
      .mat_data    (mat_data),
      .mat_valid   (mat_valid),
      .mat_ack     (mat_ack),
      .rows_loaded (rows_loaded)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_push = 0;
   int n_pop  = 0;

   // Reference model: plain element array plus block position.
   logic [ELEM_W-1:0] m_el [DIM][DIM];
   bit                m_hold;
   int                m_cnt;
   logic [MAT_W-1:0]  exp_q [$];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   function automatic logic [MAT_W-1:0] pack();
      logic [MAT_W-1:0] p;
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            p[idx(r, c) +: ELEM_W] = m_el[r][c];
      return p;
   endfunction

   task automatic chk_mat(input string name, input logic [MAT_W-1:0] exp);
      int bad;
      bad = -1;
      for (int e = DIM * DIM - 1; e >= 0; e--)
         if (mat_data[ELEM_W*e +: ELEM_W] !== exp[ELEM_W*e +: ELEM_W]) bad = e;
      n_chk++;
      if (bad < 0) n_pass++;
      else $display("FAIL %s: element (%0d,%0d) got %h expected %h", name, bad / DIM, bad % DIM,
                    mat_data[ELEM_W*bad +: ELEM_W], exp[ELEM_W*bad +: ELEM_W]);
   endtask

   function automatic void model_clear();
      for (int r = 0; r < DIM; r++)
         for (int c = 0; c < DIM; c++)
            m_el[r][c] = '0;
   endfunction

   function automatic logic [BEAT_W-1:0] ramp(input int b);
      logic [BEAT_W-1:0] v;
      for (int k = 0; k < BEAT_ELEMS; k++)
         v[ELEM_W*k +: ELEM_W] = 16'((b / 4) * DIM + (b % 4) * BEAT_ELEMS + k);
      return v;
   endfunction

   function automatic logic [BEAT_W-1:0] rnd_beat();
      logic [BEAT_W-1:0] v;
      for (int w = 0; w < BEAT_W / 32; w++) v[32*w +: 32] = $urandom;
      return v;
   endfunction

   // One clock: drive after the falling edge, model the rising edge, check on the next falling edge.
   task automatic step(input bit v, input logic [BEAT_W-1:0] d, input bit last, input bit ack);
      in_valid = v;
      in_data  = d;
      in_last  = last;
      mat_ack  = ack;
      @(posedge clk);
      if (!m_hold) begin
         if (v) begin
            for (int k = 0; k < BEAT_ELEMS; k++)
               m_el[m_cnt / 4][(m_cnt % 4) * BEAT_ELEMS + k] = d[ELEM_W*k +: ELEM_W];
            m_cnt++;
`ifdef MATRIX_LOAD_ZERO_PAD_EN
            if (last) m_cnt = BEATS_PER_MAT;
`endif
            if (m_cnt == BEATS_PER_MAT) begin
               m_hold = 1'b1;
               m_cnt  = 0;
               exp_q.push_back(pack());
               n_push++;
            end
         end
      end else if (ack) begin
         m_hold = 1'b0;
`ifdef MATRIX_LOAD_ZERO_PAD_EN
         model_clear();
`endif
      end
      @(negedge clk);
      chk("in_ready", int'(in_ready), int'(!m_hold));
      chk("mat_valid", int'(mat_valid), int'(m_hold));
      chk("rows_loaded", int'(rows_loaded), m_hold ? 64 : m_cnt / 4);
      chk_mat("mat_data", pack());
   endtask

   // Monitor: each new presented matrix is compared against the next expected block.
   bit prev_valid = 1'b0;
   always @(negedge clk) begin
      if (mat_valid && !prev_valid) begin
         n_pop++;
         if (exp_q.size() == 0) chk("unexpected_block", 1, 0);
         else chk_mat("block", exp_q.pop_front());
      end
      prev_valid = mat_valid;
   end

   initial begin
      int cyc;
      int bad;
      rst      = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_last  = 1'b0;
      mat_ack  = 1'b0;
      m_hold   = 1'b0;
      m_cnt    = 0;
      model_clear();
      repeat (3) @(negedge clk);
      chk("rst_in_ready", int'(in_ready), 1);
      chk("rst_mat_valid", int'(mat_valid), 0);
      chk("rst_rows", int'(rows_loaded), 0);
      chk_mat("rst_mat", '0);
      rst = 1'b1;
      @(negedge clk);

      // Ramp block: element (r,c) = 64r+c.
      for (int b = 0; b < BEATS_PER_MAT; b++) step(1'b1, ramp(b), 1'b0, 1'b0);
      chk("elem_5_37", int'(mat_data[idx(5, 37) +: ELEM_W]), 357);
      chk("ramp_valid", int'(mat_valid), 1);

      // Held matrix ignores in_valid.
      repeat (10) step(1'b1, rnd_beat(), 1'b0, 1'b0);
      chk("hold_rows", int'(rows_loaded), 64);

      // Ack, then a block of -32768; first beat lands one cycle after the ack.
      step(1'b1, {BEAT_ELEMS{16'h8000}}, 1'b0, 1'b1);
      step(1'b1, {BEAT_ELEMS{16'h8000}}, 1'b0, 1'b0);
      chk("bubble_first_beat", int'($signed(mat_data[idx(0, 0) +: ELEM_W])), -32768);
      chk("bubble_rows", int'(rows_loaded), 0);
      for (int b = 1; b < BEATS_PER_MAT; b++) step(1'b1, {BEAT_ELEMS{16'h8000}}, 1'b0, 1'b0);
      bad = 0;
      for (int e = 0; e < DIM * DIM; e++)
         if ($signed(mat_data[ELEM_W*e +: ELEM_W]) != -32768) bad++;
      chk("neg_elems_bad", bad, 0);
      step(1'b0, '0, 1'b0, 1'b1);

      // Random in_valid over a full block.
      cyc = 0;
      while (!m_hold && cyc < 3000) begin
         step(1'($urandom % 2), rnd_beat(), 1'b0, 1'b0);
         cyc++;
      end
      chk("random_block_timeout", int'(m_hold), 1);
      step(1'b0, '0, 1'b0, 1'b1);

      // Asynchronous reset after 100 beats.
      for (int b = 0; b < 100; b++) step(1'b1, rnd_beat(), 1'b0, 1'b0);
      rst = 1'b0;
      #1;
      m_hold = 1'b0;
      m_cnt  = 0;
      model_clear();
      chk("mid_rst_in_ready", int'(in_ready), 1);
      chk("mid_rst_rows", int'(rows_loaded), 0);
      chk_mat("mid_rst_mat", '0);
      @(negedge clk);
      rst = 1'b1;
      step(1'b0, '0, 1'b0, 1'b0);
      chk("post_rst_rows", int'(rows_loaded), 0);
      for (int b = 0; b < BEATS_PER_MAT; b++) step(1'b1, ramp(b), 1'b0, 1'b0);
      chk("post_rst_elem_63_63", int'(mat_data[idx(63, 63) +: ELEM_W]), 4095);
      step(1'b0, '0, 1'b0, 1'b1);

`ifdef MATRIX_LOAD_ZERO_PAD_EN
      for (int b = 0; b < BEATS_PER_MAT; b++) step(1'b1, rnd_beat(), 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      for (int b = 0; b < 64; b++) step(1'b1, {BEAT_ELEMS{16'd1}}, (b == 63), 1'b0);
      chk("pad_valid", int'(mat_valid), 1);
      chk("pad_elem_15_63", int'(mat_data[idx(15, 63) +: ELEM_W]), 1);
      chk("pad_elem_16_0", int'(mat_data[idx(16, 0) +: ELEM_W]), 0);
      chk("pad_elem_63_63", int'(mat_data[idx(63, 63) +: ELEM_W]), 0);
      step(1'b0, '0, 1'b0, 1'b1);
      chk_mat("pad_cleared", '0);
`endif

      @(negedge clk);
      chk("blocks_seen", n_pop, n_push);
      chk("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
